// File: rtl/axi_ram_fill.sv
// rtl/axi_ram_fill.sv - AXI4 write-master sequencer that fills a RAM region with a constant or incrementing pattern
module axi_ram_fill #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_words,
  input  logic [DATA_WIDTH-1:0] cfg_pattern,
  input  logic                  cfg_incr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int          ADDR_LSB       = $clog2(STRB_WIDTH);
  localparam logic [31:0] BOUNDARY_WORDS = 32'(4096 / STRB_WIDTH);
  localparam logic [1:0]  BURST_INCR     = 2'b01;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_RESP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] remaining_q;
  logic [DATA_WIDTH-1:0] pattern_q;
  logic                  incr_q;
  logic [7:0]            beat_q;
  logic [7:0]            len_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  error_q;

  logic                  aw_hs, w_hs, b_hs, last_beat;
  logic [8:0]            cur_beats, first_beats, next_beats;
  logic [ADDR_WIDTH-1:0] start_addr, next_addr, next_rem;
  logic                  unused_bid;

  // Beats in the next burst: bounded by remaining words, burst cap and the next 4 KB boundary.
  function automatic logic [8:0] calc_beats(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [ADDR_WIDTH-1:0] r);
    logic [31:0] to_boundary;
    logic [31:0] n;
    to_boundary = BOUNDARY_WORDS - ((32'(a) & 32'hFFF) >> ADDR_LSB);
    n = 32'(r);
    if (n > to_boundary) n = to_boundary;
    if (n > 32'(MAX_BURST_LEN)) n = 32'(MAX_BURST_LEN);
    return 9'(n);
  endfunction

  // Handshakes are decoded from state, not from the valid outputs, to keep the FSM free of comb loops.
  assign aw_hs     = (state == S_BURST) && !aw_done_q && m_axi_awready;
  assign w_hs      = (state == S_BURST) && !w_done_q && m_axi_wready;
  assign b_hs      = (state == S_RESP) && m_axi_bvalid;
  assign last_beat = (beat_q == len_q);

  assign cur_beats   = {1'b0, len_q} + 9'd1;
  assign start_addr  = cfg_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
  assign next_addr   = addr_q + (ADDR_WIDTH'(cur_beats) << ADDR_LSB);
  assign next_rem    = remaining_q - ADDR_WIDTH'(cur_beats);
  assign first_beats = calc_beats(start_addr, cfg_words);
  assign next_beats  = calc_beats(next_addr, next_rem);

  // Response ID carries no information with awid fixed at zero.
  assign unused_bid = ^m_axi_bid;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(ADDR_LSB);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = pattern_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state == S_BURST) && last_beat;
  assign error         = error_q;

  // State register; async reset abandons any fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx      = state;
    busy          = 1'b1;
    done          = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (cfg_words == '0) ? S_DONE : S_BURST;
      end
      S_BURST: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && last_beat))) state_nx = S_RESP;
      end
      S_RESP: begin
        m_axi_bready = 1'b1;
        if (b_hs) state_nx = (next_rem == '0) ? S_DONE : S_BURST;
      end
      default: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Datapath: address/remaining advance per completed burst, pattern advances per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      pattern_q   <= '0;
      incr_q      <= 1'b0;
      beat_q      <= '0;
      len_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q      <= start_addr;
            remaining_q <= cfg_words;
            pattern_q   <= cfg_pattern;
            incr_q      <= cfg_incr;
            error_q     <= 1'b0;
            beat_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            if (cfg_words != '0) len_q <= 8'(first_beats - 9'd1);
          end
        end
        S_BURST: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs) begin
            pattern_q <= pattern_q + DATA_WIDTH'(incr_q);
            beat_q    <= beat_q + 8'd1;
            if (last_beat) w_done_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (b_hs) begin
            error_q     <= error_q | (m_axi_bresp != RESP_OKAY);
            addr_q      <= next_addr;
            remaining_q <= next_rem;
            beat_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            if (next_rem != '0) len_q <= 8'(next_beats - 9'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_fill.sv
// tb/tb_axi_ram_fill.sv - directed self-checking bench for axi_ram_fill
module tb_axi_ram_fill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_addr = '0;
  logic [15:0] cfg_words = '0;
  logic [31:0] cfg_pattern = '0;
  logic        cfg_incr = 1'b0;
  logic        busy, done, error;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [7:0]  m_axi_bid = '0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  always #5 clk = ~clk;

  axi_ram_fill #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8), .MAX_BURST_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_addr(cfg_addr), .cfg_words(cfg_words),
    .cfg_pattern(cfg_pattern), .cfg_incr(cfg_incr), .busy(busy), .done(done), .error(error),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  int n_checks = 0;
  int n_pass = 0;

  // slave model state
  logic [31:0] mem [0:16383];
  int unsigned log_addr[$];
  int unsigned log_len[$];
  logic [31:0] wq[$];
  bit          bp_mode = 0;
  int          err_burst = 0;
  int          burst_idx = 0;
  int          stab_err = 0;
  int          wlast_err = 0;
  bit          aw_have, w_have, aw_wait, w_wait, b_pend, b_fire;
  int          b_cnt;
  logic [1:0]  b_resp_pend;
  logic [15:0] cur_addr, saw_addr;
  logic [7:0]  cur_len, saw_len;
  logic [31:0] saw_data;

  // AXI slave: all activity at negedge; a handshake decided here completes at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      aw_have = 0; w_have = 0; aw_wait = 0; w_wait = 0; b_pend = 0; b_fire = 0; b_cnt = 0;
      wq.delete();
    end else begin
      if (b_fire) begin m_axi_bvalid = 1'b0; b_fire = 0; end
      if (!m_axi_bvalid && b_pend) begin
        if (b_cnt == 0) begin m_axi_bvalid = 1'b1; m_axi_bresp = b_resp_pend; b_pend = 0; end
        else b_cnt--;
      end
      if (m_axi_bvalid && m_axi_bready) b_fire = 1;
      if (aw_wait && (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== saw_addr || m_axi_awlen !== saw_len)) stab_err++;
      if (w_wait && (m_axi_wvalid !== 1'b1 || m_axi_wdata !== saw_data)) stab_err++;
      m_axi_awready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axi_awvalid && m_axi_awready) begin
        cur_addr = m_axi_awaddr; cur_len = m_axi_awlen; aw_have = 1; burst_idx++;
        log_addr.push_back(int'(m_axi_awaddr)); log_len.push_back(int'(m_axi_awlen));
      end
      if (m_axi_wvalid && m_axi_wready) begin
        wq.push_back(m_axi_wdata);
        if (m_axi_wlast) w_have = 1;
      end
      aw_wait = m_axi_awvalid && !m_axi_awready; saw_addr = m_axi_awaddr; saw_len = m_axi_awlen;
      w_wait = m_axi_wvalid && !m_axi_wready; saw_data = m_axi_wdata;
      if (aw_have && w_have) begin
        if (wq.size() != int'(cur_len) + 1) wlast_err++;
        for (int i = 0; i < wq.size(); i++) mem[(int'(cur_addr >> 2) + i) % 16384] = wq[i];
        wq.delete();
        aw_have = 0; w_have = 0; b_pend = 1;
        b_cnt = bp_mode ? int'($urandom_range(0, 5)) : 0;
        b_resp_pend = (burst_idx == err_burst) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic prep(input bit bp, input int eb);
    bp_mode = bp; err_burst = eb; burst_idx = 0; stab_err = 0; wlast_err = 0;
    log_addr.delete(); log_len.delete();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 32'hDEADBEEF;
  endtask

  // Returns at the first negedge after start was sampled.
  task automatic start_fill(input logic [15:0] a, input logic [15:0] w, input logic [31:0] p, input logic inc);
    @(negedge clk);
    cfg_addr = a; cfg_words = w; cfg_pattern = p; cfg_incr = inc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0;
    while (done !== 1'b1 && cycles < 3000) begin @(negedge clk); cycles++; end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wlast} !== 7'b0)
      $display("FAIL reset_ctl: got %b expected 0", {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wlast});
    else n_pass++;
    n_checks++;
    if ({m_axi_awaddr, m_axi_awlen, m_axi_wdata} !== 56'h0)
      $display("FAIL reset_payload: got %h expected 0", {m_axi_awaddr, m_axi_awlen, m_axi_wdata});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_wstrb} !== {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'hF})
      $display("FAIL fixed_fields: got %h expected %h", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_wstrb},
               {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'hF});
    else n_pass++;
  endtask

  task automatic test_single_burst();
    int cyc; bit ok; int bad;
    prep(0, 0);
    start_fill(16'h0000, 16'd4, 32'hA5A5A5A5, 1'b0);
    n_checks++;
    if ({busy, m_axi_awvalid, m_axi_wvalid} !== 3'b111) $display("FAIL start_latency: got %b expected 111", {busy, m_axi_awvalid, m_axi_wvalid});
    else n_pass++;
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || cyc != 5) $display("FAIL single_cycles: got %0d (done=%0d) expected 5", cyc, ok); else n_pass++;
    n_checks++;
    if (log_addr.size() != 1 || log_addr[0] != 0 || log_len[0] != 3)
      $display("FAIL single_aw: got n=%0d addr=%h len=%0d expected n=1 addr=0 len=3", log_addr.size(),
               log_addr.size() > 0 ? log_addr[0] : 0, log_len.size() > 0 ? log_len[0] : 0);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 4; k++) if (mem[k] !== 32'hA5A5A5A5) bad++;
    n_checks++;
    if (bad != 0 || wlast_err != 0 || error !== 1'b0) $display("FAIL single_data: got bad=%0d wlast_err=%0d error=%b expected 0 0 0", bad, wlast_err, error);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL done_pulse: got busy,done=%b expected 00", {busy, done}); else n_pass++;
  endtask

  task automatic test_4k_split();
    int cyc; bit ok; int bad;
    prep(0, 0);
    start_fill(16'h0FF0, 16'd8, 32'h11110000, 1'b1);
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || cyc != 10) $display("FAIL split_cycles: got %0d (done=%0d) expected 10", cyc, ok); else n_pass++;
    n_checks++;
    if (log_addr.size() != 2 || log_addr[0] != 32'h0FF0 || log_len[0] != 3 || log_addr[1] != 32'h1000 || log_len[1] != 3)
      $display("FAIL split_aw: got n=%0d expected 0FF0/3,1000/3", log_addr.size());
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 8; k++) if (mem[16'h03FC + k] !== 32'h11110000 + k) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL split_data: got %0d bad words expected 0", bad); else n_pass++;
  endtask

  task automatic test_multi_incr();
    int cyc; bit ok; int bad;
    prep(0, 0);
    start_fill(16'h0100, 16'd40, 32'h00000100, 1'b1);
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || cyc != 43) $display("FAIL multi_cycles: got %0d (done=%0d) expected 43", cyc, ok); else n_pass++;
    n_checks++;
    if (log_addr.size() != 3 || log_len[0] != 15 || log_len[1] != 15 || log_len[2] != 7 ||
        log_addr[0] != 32'h0100 || log_addr[1] != 32'h0140 || log_addr[2] != 32'h0180)
      $display("FAIL multi_aw: got n=%0d expected 0100/15,0140/15,0180/7", log_addr.size());
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 40; k++) if (mem[16'h0040 + k] !== 32'h100 + k) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL multi_data: got %0d bad words expected 0", bad); else n_pass++;
  endtask

  task automatic test_addr_wrap();
    int cyc; bit ok; int bad;
    prep(0, 0);
    start_fill(16'hFFF8, 16'd4, 32'h00007000, 1'b1);
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || log_addr.size() != 2 || log_addr[0] != 32'hFFF8 || log_len[0] != 1 || log_addr[1] != 32'h0000 || log_len[1] != 1)
      $display("FAIL wrap_aw: got n=%0d done=%0d expected FFF8/1,0000/1", log_addr.size(), ok);
    else n_pass++;
    bad = 0;
    if (mem[16'h3FFE] !== 32'h7000) bad++;
    if (mem[16'h3FFF] !== 32'h7001) bad++;
    if (mem[0] !== 32'h7002) bad++;
    if (mem[1] !== 32'h7003) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL wrap_data: got %0d bad words expected 0", bad); else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc; bit ok; int bad;
    prep(1, 0);
    start_fill(16'h2002, 16'd40, 32'hCAFE0000, 1'b1);
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || log_addr.size() != 3 || log_addr[0] != 32'h2000 || log_addr[1] != 32'h2040 || log_addr[2] != 32'h2080 || log_len[2] != 7)
      $display("FAIL bp_aw: got n=%0d done=%0d expected 2000,2040,2080", log_addr.size(), ok);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 40; k++) if (mem[16'h0800 + k] !== 32'hCAFE0000 + k) bad++;
    n_checks++;
    if (bad != 0 || error !== 1'b0) $display("FAIL bp_data: got bad=%0d error=%b expected 0 0", bad, error); else n_pass++;
    n_checks++;
    if (stab_err != 0 || wlast_err != 0) $display("FAIL bp_stable: got stab=%0d wlast=%0d expected 0 0", stab_err, wlast_err); else n_pass++;
    bp_mode = 0;
  endtask

  task automatic test_error();
    int cyc; bit ok;
    prep(0, 2);
    start_fill(16'h0300, 16'd40, 32'h0, 1'b1);
    wait_done(cyc, ok);
    n_checks++;
    if (!ok || log_addr.size() != 3 || error !== 1'b1) $display("FAIL err_resp: got n=%0d error=%b expected 3 1", log_addr.size(), error);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (error !== 1'b1) $display("FAIL err_sticky: got %b expected 1", error); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int cyc; bit ok; int bad;
    prep(0, 0);
    start_fill(16'h0400, 16'd8, 32'h00000055, 1'b0);
    n_checks++;
    if (error !== 1'b0) $display("FAIL err_clear: got %b expected 0", error); else n_pass++;
    cfg_addr = 16'h0800; cfg_words = 16'd4; cfg_pattern = 32'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, ok);
    bad = 0;
    for (int k = 0; k < 8; k++) if (mem[16'h0100 + k] !== 32'h55) bad++;
    if (mem[16'h0200] !== 32'hDEADBEEF) bad++;
    n_checks++;
    if (!ok || log_addr.size() != 1 || log_addr[0] != 32'h0400 || log_len[0] != 7 || bad != 0)
      $display("FAIL busy_start: got n=%0d bad=%0d expected 1 burst 0400/7, 0 bad", log_addr.size(), bad);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    prep(0, 0);
    start_fill(16'h0500, 16'd0, 32'h1, 1'b0);
    n_checks++;
    if ({done, busy, m_axi_awvalid, m_axi_wvalid} !== 4'b1100) $display("FAIL zero_done: got %b expected 1100", {done, busy, m_axi_awvalid, m_axi_wvalid});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00 || log_addr.size() != 0) $display("FAIL zero_after: got %b n=%0d expected 00 n=0", {done, busy}, log_addr.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen_done;
    prep(0, 0);
    start_fill(16'h3000, 16'd16, 32'h9000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_axi_awvalid, m_axi_wvalid, busy, done} !== 4'b0000) $display("FAIL reset_mid: got %b expected 0000", {m_axi_awvalid, m_axi_wvalid, busy, done});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (6) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen_done++; end
    n_checks++;
    if (seen_done != 0) $display("FAIL reset_no_done: got %0d active cycles expected 0", seen_done); else n_pass++;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_single_burst();
    test_4k_split();
    test_multi_incr();
    test_addr_wrap();
    test_backpressure();
    test_error();
    test_start_while_busy();
    test_zero_len();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
